wb_fml_bridge: RTL and testbench

WB_FML_BRIDGE -- requirements
Module: wb_fml_bridge

---
 rtl/wb_fml_pkg.sv | 25 ++
 rtl/wb_fml_rdbuf.sv | 32 +++
 rtl/wb_fml_bridge.sv | 124 ++++++++++++
 tb/tb_wb_fml_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fml_pkg.sv
// Shared constants for the Wishbone-to-FML bridge.
// FSM state codes, FML line geometry and the write byte-mask helper.
package wb_fml_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam int FML_DW    = 128;
    localparam int FML_MW    = 16;
    localparam int FML_WORDS = 4;

    // Mask bit set = byte masked; only the bytes selected in word w pass.
    function automatic logic [FML_MW-1:0] byte_mask(
        input logic [1:0] w,
        input logic [3:0] sel
    );
        logic [FML_MW-1:0] m;
        m = '1;
        m[{w, 2'b00} +: 4] = ~sel;
        return m;
    endfunction

endpackage

// File: rtl/wb_fml_rdbuf.sv
// Valid bit and line tag for the bridge's single-line read buffer.
// Built only when WB_FML_RDBUF_EN is defined.
module wb_fml_rdbuf #(
    parameter int aw = 25
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          fill,
    input  logic [aw-1:0] fill_adr,
    input  logic [aw-1:0] look_adr,
    input  logic [aw-1:0] cmp_adr,
    output logic          hit,
    output logic          match
);

    logic          valid;
    logic [aw-1:0] tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_adr;
        end
    end

    assign hit   = valid && (tag == look_adr);
    assign match = valid && (tag == cmp_adr);

endmodule

// File: rtl/wb_fml_bridge.sv
// Wishbone classic slave to FML line-burst master bridge.
// Define WB_FML_RDBUF_EN to keep the last read line as a one-entry cache.
module wb_fml_bridge
    import wb_fml_pkg::*;
#(
    parameter int fml_adr_width = 25
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [31:0]              wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    input  logic [3:0]               wb_sel_i,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     fml_rd,
    output logic                     fml_wr,
    output logic [fml_adr_width-1:0] fml_adr,
    output logic [FML_DW-1:0]        fml_din,
    output logic [FML_MW-1:0]        fml_msk,
    input  logic                     fml_done,
    input  logic [FML_DW-1:0]        fml_dout
);

    logic [1:0]               state;
    logic [1:0]               word_q;
    logic                     abort_q;
    logic [FML_DW-1:0]        line_q;
    logic                     req;
    logic                     hit;
    logic                     wmatch;
    logic [fml_adr_width-1:0] req_adr;
    logic                     unused;

    assign req     = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign req_adr = wb_adr_i[fml_adr_width+3:4];
    assign unused  = &{1'b0, wb_adr_i};

`ifdef WB_FML_RDBUF_EN
    wb_fml_rdbuf #(
        .aw(fml_adr_width)
    ) u_rdbuf (
        .clk     (clk),
        .reset_n (reset_n),
        .fill    (state == S_READ && fml_done),
        .fill_adr(fml_adr),
        .look_adr(req_adr),
        .cmp_adr (fml_adr),
        .hit     (hit),
        .match   (wmatch)
    );
`else
    assign hit    = 1'b0;
    assign wmatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            word_q   <= '0;
            abort_q  <= 1'b0;
            line_q   <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            fml_rd   <= 1'b0;
            fml_wr   <= 1'b0;
            fml_adr  <= '0;
            fml_din  <= '0;
            fml_msk  <= '1;
        end else begin
            wb_ack_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        fml_adr <= req_adr;
                        word_q  <= wb_adr_i[3:2];
                        abort_q <= 1'b0;
                        if (wb_we_i) begin
                            fml_din <= {FML_WORDS{wb_dat_i}};
                            fml_msk <= byte_mask(wb_adr_i[3:2], wb_sel_i);
                            fml_wr  <= 1'b1;
                            state   <= S_WRITE;
                        end else if (hit) begin
                            state <= S_ACK;
                        end else begin
                            fml_rd <= 1'b1;
                            state  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (!wb_cyc_i) abort_q <= 1'b1;
                    if (fml_done) begin
                        fml_rd <= 1'b0;
                        line_q <= fml_dout;
                        state  <= S_ACK;
                    end
                end
                S_WRITE: begin
                    if (!wb_cyc_i) abort_q <= 1'b1;
                    if (fml_done) begin
                        fml_wr <= 1'b0;
                        state  <= S_ACK;
                        // Keep a buffered copy of this line coherent.
                        if (wmatch) begin
                            for (int b = 0; b < FML_MW; b++) begin
                                if (!fml_msk[b])
                                    line_q[8*b +: 8] <= fml_din[8*b +: 8];
                            end
                        end
                    end
                end
                default: begin
                    wb_ack_o <= !abort_q && wb_cyc_i;
                    wb_dat_o <= line_q[{word_q, 5'b00000} +: 32];
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_fml_bridge.sv
// Self-checking bench for wb_fml_bridge: vector table, random traffic
// against a line-memory reference model, and abort/reset corner cases.
module tb_wb_fml_bridge;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0]  wb_adr_i, wb_dat_i;
    logic [3:0]   wb_sel_i;
    logic [31:0]  wb_dat_o;
    logic         wb_ack_o;
    logic         fml_rd, fml_wr;
    logic [24:0]  fml_adr;
    logic [127:0] fml_din;
    logic [15:0]  fml_msk;
    logic         fml_done;
    logic [127:0] fml_dout;

    int tests = 0;
    int fails = 0;

    logic [127:0] mem [logic [24:0]];
    logic         cv = 1'b0;
    logic [24:0]  ct = '0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          lat;
        logic [24:0] exp_adr;
        logic [15:0] exp_msk;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[11];

    wb_fml_bridge #(.fml_adr_width(25)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .fml_rd(fml_rd), .fml_wr(fml_wr), .fml_adr(fml_adr),
        .fml_din(fml_din), .fml_msk(fml_msk),
        .fml_done(fml_done), .fml_dout(fml_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [24:0] la);
        return {32'h3000_0000 | 32'(la), 32'h2000_0000 | 32'(la),
                32'h1000_0000 | 32'(la), 32'h0F00_0000 | 32'(la)};
    endfunction

    // One Wishbone transaction with the bench acting as FML slave.
    task automatic txn(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input int lat, input int drop_at, input string tag,
                       output int o_str, output logic [24:0] o_adr,
                       output logic [15:0] o_msk, output logic [31:0] o_rd);
        logic [24:0]  la;
        int           w;
        logic         hit_exp;
        logic [15:0]  m_exp;
        logic [127:0] line, t, d0;
        int           n_str, done_c, ack_c, n_ack;
        logic         stable, saw_rd, saw_wr, post_ok;
        la = adr[28:4];
        w = int'(adr[3:2]);
        n_str = 0; done_c = -1; ack_c = -1; n_ack = 0;
        stable = 1'b1; saw_rd = 1'b0; saw_wr = 1'b0; post_ok = 1'b1;
        o_adr = '0; o_msk = '1; o_rd = '0; d0 = '0;
        if (!mem.exists(la)) mem[la] = init_line(la);
        line = mem[la];
        hit_exp = 1'b0;
`ifdef WB_FML_RDBUF_EN
        hit_exp = !we && cv && (ct == la);
`endif
        m_exp = 16'hFFFF;
        for (int b = 0; b < 4; b++) if (sel[b]) m_exp[4*w+b] = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        for (int c = 1; c <= lat + 12; c++) begin
            @(posedge clk); #1;
            fml_done = 1'b0;
            if (done_c >= 0 && c == done_c + 1 && (fml_rd || fml_wr))
                post_ok = 1'b0;
            if (fml_rd || fml_wr) begin
                saw_rd |= fml_rd;
                saw_wr |= fml_wr;
                n_str++;
                if (n_str == 1) begin
                    o_adr = fml_adr; o_msk = fml_msk; d0 = fml_din;
                end else if (fml_adr !== o_adr || fml_msk !== o_msk ||
                             fml_din !== d0) begin
                    stable = 1'b0;
                end
                if (n_str == lat) begin
                    fml_done = 1'b1;
                    fml_dout = we ? {4{$urandom}} : line;
                    done_c = c;
                end
            end
            if (wb_ack_o) begin
                n_ack++;
                if (ack_c < 0) begin
                    ack_c = c;
                    o_rd = wb_dat_o;
                end
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            if (c == drop_at) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            if (ack_c >= 0 && c >= ack_c + 2) break;
            if (drop_at > 0 && done_c >= 0 && c >= done_c + 4) break;
        end
        fml_done = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        o_str = n_str;
        chk({tag, " ack count"}, 128'(n_ack), (drop_at > 0) ? 128'd0 : 128'd1);
        if (drop_at == 0)
            chk({tag, " ack cycle"}, 128'(ack_c),
                hit_exp ? 128'd2 : 128'(lat + 2));
        if (hit_exp) begin
            chk({tag, " hit no fml"}, 128'({saw_rd, saw_wr}), 128'd0);
        end else begin
            chk({tag, " strobe cycles"}, 128'(n_str), 128'(lat));
            chk({tag, " rd/wr kind"}, 128'({saw_rd, saw_wr}),
                128'({!we, we}));
            chk({tag, " fml_adr"}, 128'(o_adr), 128'(la));
            chk({tag, " held stable"}, 128'(stable), 128'd1);
            chk({tag, " strobe drop"}, 128'(post_ok), 128'd1);
        end
        if (we) begin
            chk({tag, " fml_msk"}, 128'(o_msk), 128'(m_exp));
            chk({tag, " fml_din"}, d0, {4{dat}});
            t = mem[la];
            for (int b = 0; b < 4; b++)
                if (sel[b]) t[32*w + 8*b +: 8] = dat[8*b +: 8];
            mem[la] = t;
        end else begin
            if (drop_at == 0)
                chk({tag, " rdata"}, 128'(o_rd), 128'(line[32*w +: 32]));
            if (!hit_exp) begin
                cv = 1'b1; ct = la;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " fml_rd"}, 128'(fml_rd), 128'd0);
        chk({tag, " fml_wr"}, 128'(fml_wr), 128'd0);
        chk({tag, " wb_ack_o"}, 128'(wb_ack_o), 128'd0);
        chk({tag, " fml_msk"}, 128'(fml_msk), 128'hFFFF);
        chk({tag, " fml_adr"}, 128'(fml_adr), 128'd0);
        chk({tag, " fml_din"}, fml_din, 128'd0);
        chk({tag, " wb_dat_o"}, 128'(wb_dat_o), 128'd0);
    endtask

    initial begin
        int          s;
        logic [24:0] a;
        logic [15:0] m;
        logic [31:0] r;
        logic [24:0] lines [5];
        logic [24:0] la;

        vt[0]  = '{0, 32'h0000_0014, 32'h0, 4'h0, 5,
                   25'h1, 16'hFFFF, 32'h2222_2222};
        vt[1]  = '{1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b0011, 3,
                   25'h0, 16'hFCFF, 32'h0};
        vt[2]  = '{0, 32'h0000_0008, 32'h0, 4'h0, 2,
                   25'h0, 16'hFFFF, 32'h0000_BEEF};
        vt[3]  = '{1, 32'h0000_001C, 32'h1234_5678, 4'b1000, 1,
                   25'h1, 16'h7FFF, 32'h0};
        vt[4]  = '{0, 32'h0000_001C, 32'h0, 4'h0, 4,
                   25'h1, 16'hFFFF, 32'h1244_4444};
        vt[5]  = '{0, 32'h0000_0010, 32'h0, 4'h0, 1,
                   25'h1, 16'hFFFF, 32'h1111_1111};
        vt[6]  = '{1, 32'h0000_0018, 32'h0000_00AA, 4'hF, 2,
                   25'h1, 16'hF0FF, 32'h0};
        vt[7]  = '{0, 32'h0000_0018, 32'h0, 4'h0, 3,
                   25'h1, 16'hFFFF, 32'h0000_00AA};
        vt[8]  = '{0, 32'hFFFF_FFF4, 32'h0, 4'h0, 6,
                   25'h1FF_FFFF, 16'hFFFF, 32'h0000_00B1};
        vt[9]  = '{1, 32'h0000_0004, 32'hCAFE_F00D, 4'b0101, 2,
                   25'h0, 16'hFFAF, 32'h0};
        vt[10] = '{0, 32'h0000_0004, 32'h0, 4'h0, 1,
                   25'h0, 16'hFFFF, 32'h00FE_000D};

        mem[25'h0] = '0;
        mem[25'h1] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        mem[25'h1FF_FFFF] = 128'h0000_00D3_0000_00C2_0000_00B1_0000_00A0;

        reset_n = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        fml_done = 1'b0; fml_dout = '0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("post-reset idle");

        for (int i = 0; i < 11; i++) begin
            txn(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, vt[i].lat, 0,
                $sformatf("vec%0d", i), s, a, m, r);
            if (s > 0) chk($sformatf("vec%0d table adr", i),
                           128'(a), 128'(vt[i].exp_adr));
            if (vt[i].we) chk($sformatf("vec%0d table msk", i),
                              128'(m), 128'(vt[i].exp_msk));
            else chk($sformatf("vec%0d table rdata", i),
                     128'(r), 128'(vt[i].exp_rd));
        end

        // Master gives up two cycles into a miss.
        txn(0, 32'h0000_0038, 32'h0, 4'h0, 6, 2, "abort", s, a, m, r);
        txn(0, 32'h0000_003C, 32'h0, 4'h0, 2, 0, "after abort", s, a, m, r);

        // A stray fml_done while idle must do nothing.
        fml_done = 1'b1; fml_dout = {4{32'hBAD0_BAD0}};
        @(posedge clk); #1;
        fml_done = 1'b0;
        chk("stray done ack", 128'(wb_ack_o), 128'd0);
        chk("stray done strobes", 128'({fml_rd, fml_wr}), 128'd0);
        @(posedge clk); #1;
        chk("stray done ack2", 128'(wb_ack_o), 128'd0);
        txn(0, 32'h0000_0034, 32'h0, 4'h0, 2, 0, "after stray", s, a, m, r);

        // Reset lands in the middle of a read miss.
        txn(0, 32'h0000_0020, 32'h0, 4'h0, 2, 0, "prefill", s, a, m, r);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h0000_0054;
        @(posedge clk); #1;
        chk("mid-read fml_rd", 128'(fml_rd), 128'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        cv = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        txn(0, 32'h0000_0024, 32'h0, 4'h0, 3, 0, "post-rst", s, a, m, r);

        lines = '{25'h0, 25'h1, 25'h2, 25'h3, 25'h1FF_FFFF};
        for (int i = 0; i < 60; i++) begin
            la = lines[$urandom_range(0, 4)];
            txn($urandom_range(0, 2) == 0,
                {3'($urandom), la, 2'($urandom), 2'($urandom)},
                $urandom, 4'($urandom), $urandom_range(1, 7), 0,
                $sformatf("rnd%0d", i), s, a, m, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
